muldiv_sequencer: RTL

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage. Latches operands, runs a radix-2

---
 rtl/muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage. Operands are
//   latched on acceptance, a radix-2 restoring divider (and optionally an
//   iterative shift-add multiplier) runs in BUSY, and the pipeline is stalled
//   until the result is ready. The 64-bit {hi,lo} result is presented with a
//   one-cycle result_valid pulse for the HI/LO register write.
//
//   Build option: define MULDIV_ITER_MUL_EN to run MULT/MULTU as a WIDTH-cycle
//   shift-add in BUSY. When undefined, multiplies are computed in one cycle on
//   the IDLE->DONE transition.
//
// Ports
//   clk           in   clock
//   rst           in   synchronous reset, active-high
//   start         in   EX holds a mul/div instruction (held high while stalled)
//   op            in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a             in   rs operand (dividend / multiplicand)
//   b             in   rt operand (divisor / multiplier)
//   flush         in   cancel the in-flight operation, return to IDLE
//   stall         out  freeze IF..EX while the operation is incomplete
//   busy          out  state != IDLE
//   result_valid  out  one-cycle pulse, hi/lo hold a fresh result
//   hi            out  remainder (div) / upper product (mul)
//   lo            out  quotient (div) / lower product (mul)
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's complement negate when en is set.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // remainder (div) / upper accumulator (mul)
  logic [WIDTH-1:0] quo_q, quo_d;     // quotient (div) / multiplier shifting out (mul)
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor (div) / multiplicand (mul)
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;  // result sign: a^b, signed ops only
  logic             neg_rem_q, neg_rem_d;  // remainder sign: a, signed ops only
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             rv_q, rv_d;

  logic             signed_op_s;
  logic             sgn_quo_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;
  logic             last_s;
`ifdef MULDIV_ITER_MUL_EN
  logic [WIDTH:0]   sum_s;
`else
  logic [2*WIDTH-1:0] prod_s;
`endif

  // Operand magnitudes and sign decode for the incoming instruction.
  always_comb begin
    signed_op_s = ~op[0];
    sgn_quo_s   = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
    abs_a_s     = neg_w(a, signed_op_s & a[WIDTH-1]);
    abs_b_s     = neg_w(b, signed_op_s & b[WIDTH-1]);
`ifndef MULDIV_ITER_MUL_EN
    prod_s      = {{WIDTH{1'b0}}, abs_a_s} * {{WIDTH{1'b0}}, abs_b_s};
`endif
  end

  // One iteration of the restoring divider or shift-add multiplier.
  always_comb begin
    // Divider: shift {rem,quo} left, trial-subtract; top bit of diff is the borrow.
    rem_sh_s   = {rem_q, quo_q[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, dsr_q};
`ifdef MULDIV_ITER_MUL_EN
    // Multiplier: conditionally add, then shift {carry,acc,multiplier} right.
    sum_s      = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dsr_q} : {(WIDTH+1){1'b0}});
`endif
    step_rem_s = rem_q;
    step_quo_s = quo_q;
    if (is_div_q) begin
      if (diff_s[WIDTH]) begin
        step_rem_s = rem_sh_s[WIDTH-1:0];
        step_quo_s = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_rem_s = diff_s[WIDTH-1:0];
        step_quo_s = {quo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
`ifdef MULDIV_ITER_MUL_EN
      step_rem_s = sum_s[WIDTH:1];
      step_quo_s = {sum_s[0], quo_q[WIDTH-1:1]};
`else
      step_rem_s = rem_q;
      step_quo_s = quo_q;
`endif
    end
  end

  assign last_s = (count_q == CW'(WIDTH - 1));

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rv_d      = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_d   = {CW{1'b0}};
            is_div_d  = op[1];
            neg_quo_d = sgn_quo_s;
            neg_rem_d = signed_op_s & a[WIDTH-1];
            b_zero_d  = (b == {WIDTH{1'b0}});
            rem_d     = {WIDTH{1'b0}};
            if (op[1]) begin
              quo_d   = abs_a_s;
              dsr_d   = abs_b_s;
              state_d = S_BUSY;
            end else begin
`ifdef MULDIV_ITER_MUL_EN
              quo_d   = abs_b_s;
              dsr_d   = abs_a_s;
              state_d = S_BUSY;
`else
              {hi_d, lo_d} = neg_2w(prod_s, sgn_quo_s);
              rv_d    = 1'b1;
              state_d = S_DONE;
`endif
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          count_d = count_q + CW'(1);
          rem_d   = step_rem_s;
          quo_d   = step_quo_s;
          if (last_s) begin
            state_d = S_DONE;
            rv_d    = 1'b1;
            if (is_div_q) begin
              // With b==0 the divider leaves |a| in rem, so the remainder fixup
              // restores the original a; the quotient is forced to all ones.
              hi_d = neg_w(step_rem_s, neg_rem_q);
              lo_d = b_zero_q ? {WIDTH{1'b1}} : neg_w(step_quo_s, neg_quo_q);
            end else begin
              {hi_d, lo_d} = neg_2w({step_rem_s, step_quo_s}, neg_quo_q);
            end
          end else begin
            state_d = S_BUSY;
          end
        end
        S_DONE: begin
          // start still high here belongs to the instruction just completed.
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= {CW{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      dsr_q     <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rv_q      <= rv_d;
    end
  end

  // A flush arriving in the DONE cycle suppresses the write pulse.
  assign stall        = ~rst & ~flush & (((state_q == S_IDLE) & start) | (state_q == S_BUSY));
  assign busy         = (state_q != S_IDLE);
  assign result_valid = rv_q & ~flush;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule
